// File: rtl/noc_output_port_scheduler.sv
// Wormhole output-port scheduler: round-robin packet arbitration, grant locked until the tail flit, credit-gated transfers.
// Optional lock watchdog enabled by defining SCHED_WATCHDOG_EN.
module noc_output_port_scheduler #(
    parameter int N           = 5,
    parameter int DEPTH       = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               req,
    input  logic [N-1:0]               tail,
    input  logic                       credit_in,
    output logic [N-1:0]               gnt,
    output logic                       xfer,
    output logic [$clog2(DEPTH+1)-1:0] credit,
    output logic                       wdog_err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    if (WDOG_CYCLES < 2) begin : g_wdog_cfg_check
        $error("WDOG_CYCLES must be at least 2");
    end

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [IW-1:0] owner, owner_nxt;
    logic [N-1:0]  gnt_nxt;
    logic [CW-1:0] credit_nxt;
    logic          found;
    logic [IW-1:0] win;
    logic          wdog_fire;

    // Saturating credit step: simultaneous consume and return cancel out.
    function automatic logic [CW-1:0] credit_update(input logic [CW-1:0] c,
                                                    input logic dec,
                                                    input logic inc);
        if (dec && !inc) return c - 1'b1;
        if (inc && !dec && c != CW'(DEPTH)) return c + 1'b1;
        return c;
    endfunction

    assign xfer = (state == LOCK) && req[owner] && (credit != '0);

    // Round-robin search starting just after the last packet's owner.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = ptr;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        gnt_nxt   = gnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = LOCK;
                    owner_nxt = win;
                    gnt_nxt   = N'(1) << win;
                end
            end
            LOCK: begin
                if ((xfer && tail[owner]) || wdog_fire) begin
                    state_nxt = IDLE;
                    ptr_nxt   = owner;
                    gnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        credit_nxt = credit_update(credit, xfer, credit_in);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= IW'(N - 1);
            owner  <= '0;
            gnt    <= '0;
            credit <= CW'(DEPTH);
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            owner  <= owner_nxt;
            gnt    <= gnt_nxt;
            credit <= credit_nxt;
        end
    end

`ifdef SCHED_WATCHDOG_EN
    localparam int AW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

    logic [AW-1:0] age;

    // Age is zero throughout IDLE, so it starts at zero on every lock entry.
    assign wdog_fire = (state == LOCK) && !xfer && (age == AW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            age      <= '0;
            wdog_err <= 1'b0;
        end else begin
            age      <= (state != LOCK || xfer || wdog_fire) ? '0 : age + 1'b1;
            wdog_err <= wdog_fire;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign wdog_err  = 1'b0;
`endif

endmodule

// File: tb/tb_noc_output_port_scheduler.sv
// Directed bench for noc_output_port_scheduler: expected transfers are queued by the stimulus and
// checked by an independent monitor on every cycle where xfer is asserted.
module tb_noc_output_port_scheduler;

    localparam int N = 5;
    localparam int DEPTH = 4;
    localparam int WDOG = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic [4:0] tail;
    logic       credit_in;
    logic [4:0] gnt;
    logic       xfer;
    logic [2:0] credit;
    logic       wdog_err;

    typedef struct packed {
        logic [4:0] g;
        logic [2:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    noc_output_port_scheduler #(.N(N), .DEPTH(DEPTH), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst(rst), .req(req), .tail(tail), .credit_in(credit_in),
        .gnt(gnt), .xfer(xfer), .credit(credit), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] g, input logic [2:0] c);
        exp_t e;
        e.g = g;
        e.c = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every transfer must match the next queued expectation.
    always @(negedge clk) begin
        if (xfer === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", {27'd0, gnt}, 32'h0);
                chk("unexpected_xfer_flag", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("xfer_gnt", {27'd0, gnt}, {27'd0, e.g});
                chk("xfer_credit", {29'd0, credit}, {29'd0, e.c});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req = '0; tail = '0; credit_in = 1'b0;
        tick(); tick();
        chk("reset_gnt", {27'd0, gnt}, 32'h0);
        chk("reset_credit", {29'd0, credit}, 32'd4);
        chk("reset_xfer", {31'd0, xfer}, 32'd0);
        chk("reset_wdog", {31'd0, wdog_err}, 32'd0);

        // Two single-flit packets on inputs 0 and 2.
        rst = 1'b0; req = 5'b00101; tail = 5'b00101;
        push(5'b00001, 3'd4);
        push(5'b00100, 3'd3);
        tick();
        chk("t1_gnt0", {27'd0, gnt}, 32'h01);
        tick();
        chk("t1_bubble_gnt", {27'd0, gnt}, 32'h0);
        chk("t1_bubble_xfer", {31'd0, xfer}, 32'd0);
        tick();
        chk("t1_gnt2", {27'd0, gnt}, 32'h04);
        tick();
        req = '0;
        chk("t1_credit_end", {29'd0, credit}, 32'd2);

        // Refill credits, then check saturation at DEPTH.
        credit_in = 1'b1;
        tick(); tick();
        chk("refill_credit", {29'd0, credit}, 32'd4);
        tick();
        credit_in = 1'b0;
        chk("credit_saturate", {29'd0, credit}, 32'd4);

        // Inputs 3 and 0 with continuous single-flit packets must alternate.
        req = 5'b01001; tail = 5'b01001;
        push(5'b01000, 3'd4);
        push(5'b00001, 3'd3);
        push(5'b01000, 3'd2);
        push(5'b00001, 3'd2);
        tick();
        chk("rr_gnt_a", {27'd0, gnt}, 32'h08);
        tick(); tick();
        chk("rr_gnt_b", {27'd0, gnt}, 32'h01);
        tick(); tick();
        credit_in = 1'b1;
        chk("rr_gnt_c", {27'd0, gnt}, 32'h08);
        tick();
        credit_in = 1'b0;
        chk("credit_inc_dec_same_cycle", {29'd0, credit}, 32'd2);
        tick();
        chk("rr_gnt_d", {27'd0, gnt}, 32'h01);
        tick();
        req = '0; tail = '0;
        chk("rr_credit_end", {29'd0, credit}, 32'd1);

        // Six-flit packet on input 1, throttled by credits.
        credit_in = 1'b1;
        tick(); tick(); tick();
        credit_in = 1'b0;
        chk("pre_long_credit", {29'd0, credit}, 32'd4);
        req = 5'b00010; tail = 5'b00000;
        push(5'b00010, 3'd4);
        push(5'b00010, 3'd3);
        push(5'b00010, 3'd2);
        push(5'b00010, 3'd1);
        repeat (5) tick();
        chk("long_stall_credit", {29'd0, credit}, 32'd0);
        chk("long_stall_xfer", {31'd0, xfer}, 32'd0);
        chk("long_stall_gnt", {27'd0, gnt}, 32'h02);
        tick();
        chk("long_stall_gnt_held", {27'd0, gnt}, 32'h02);
        credit_in = 1'b1;
        push(5'b00010, 3'd1);
        tick();
        credit_in = 1'b0;
        chk("long_resume_xfer", {31'd0, xfer}, 32'd1);
        tick();
        credit_in = 1'b1;
        chk("long_stall2_xfer", {31'd0, xfer}, 32'd0);
        push(5'b00010, 3'd1);
        tick();
        credit_in = 1'b0;
        tail = 5'b00010;
        tick();
        req = '0; tail = '0;
        chk("long_release_gnt", {27'd0, gnt}, 32'h0);
        chk("long_release_credit", {29'd0, credit}, 32'd0);

        // Reset while locked mid-packet on input 4.
        credit_in = 1'b1;
        repeat (4) tick();
        credit_in = 1'b0;
        req = 5'b10000; tail = 5'b00000;
        push(5'b10000, 3'd4);
        push(5'b10000, 3'd3);
        tick();
        chk("pkt4_gnt", {27'd0, gnt}, 32'h10);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midpkt_rst_gnt", {27'd0, gnt}, 32'h0);
        chk("midpkt_rst_credit", {29'd0, credit}, 32'd4);
        req = 5'b11111; tail = 5'b11111;
        push(5'b00001, 3'd4);
        tick();
        chk("post_rst_first_gnt", {27'd0, gnt}, 32'h01);
        tick();
        req = 5'b00100; tail = 5'b00000;
        chk("post_rst_idle_gnt", {27'd0, gnt}, 32'h0);

        // Input 2 granted, then its request stalls for the watchdog window.
        tick();
        chk("wd_gnt2", {27'd0, gnt}, 32'h04);
        req = 5'b01000; tail = 5'b01000;
        repeat (7) tick();
        chk("wd_pre_gnt", {27'd0, gnt}, 32'h04);
        chk("wd_pre_err", {31'd0, wdog_err}, 32'd0);
`ifdef SCHED_WATCHDOG_EN
        tick();
        chk("wd_release_gnt", {27'd0, gnt}, 32'h0);
        chk("wd_err_pulse", {31'd0, wdog_err}, 32'd1);
        push(5'b01000, 3'd3);
        tick();
        chk("wd_next_gnt3", {27'd0, gnt}, 32'h08);
        chk("wd_err_clear", {31'd0, wdog_err}, 32'd0);
        tick();
        req = '0; tail = '0;
        chk("wd_final_credit", {29'd0, credit}, 32'd2);
`else
        repeat (4) tick();
        chk("nowd_lock_held", {27'd0, gnt}, 32'h04);
        chk("nowd_err_tied", {31'd0, wdog_err}, 32'd0);
        req = '0; tail = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("nowd_rst_gnt", {27'd0, gnt}, 32'h0);
`endif
        tick(); tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/noc_output_port_scheduler.md
Name: noc_output_port_scheduler

Overview:
- Per-output-port wormhole arbiter for the mesh router.
- Shares one output link among N input ports. The grant is locked from a packet's first flit until its tail flit has transferred.
- Priority is round-robin between packets, so no input can starve another.
- Transfers are gated by a credit counter that tracks free slots in the downstream input buffer.

Parameters:
- N, 5, number of requesting input ports (E, W, N, S, local).
- DEPTH, 4, downstream buffer depth in flits; also the initial credit count.
- WDOG_CYCLES, 64, lock watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  N  req[i]=1: input i has a valid flit at its buffer head
- tail  in  N  tail[i]=1: the flit at input i's head is a tail flit; a single-flit packet has head=tail
- credit_in  in  1  one-cycle pulse: downstream freed one buffer slot
- gnt  out  N  registered one-hot grant; all-zero when idle
- xfer  out  1  combinational; a flit moves from the granted input to the link this cycle
- credit  out  $clog2(DEPTH+1)  current credit count
- wdog_err  out  1  one-cycle pulse on watchdog release; tied 0 when the optional feature is off

Behaviour:
- Reset values: state=IDLE, gnt=0, ptr=N-1 (so input 0 has highest priority first), credit=DEPTH, wdog_err=0. A reset mid-packet abandons the lock and takes effect at the next clock edge.
- State IDLE:
  - Search candidates ptr+1, ptr+2, … modulo N.
  - The first i with req[i]=1 wins: gnt<=onehot(i), owner<=i, state<=LOCK.
  - If req=0, remain in IDLE.
  - Grant latency is one cycle from req to gnt. Credit is not considered when granting.
- State LOCK:
  - xfer = req[owner] & (credit!=0). xfer is never asserted in IDLE.
  - If xfer & tail[owner]: state<=IDLE, ptr<=owner, gnt<=0.
  - Otherwise hold the lock, including while req[owner] is low mid-packet (upstream stall) or credit is 0.
  - Requests from other inputs are ignored while locked.
- Throughput: one flit per cycle while locked. There is exactly one idle bubble cycle between consecutive packets.
- Credit update, applied every cycle:
  - xfer only: credit-1.
  - credit_in only: credit+1.
  - Both: unchanged.
  - credit_in while credit==DEPTH with no xfer: held at DEPTH (saturate, no wrap).
  - credit never underflows, because xfer requires credit!=0.
- ptr arithmetic wraps: owner N-1 is followed by candidate 0.

Optional Feature:
- Macro SCHED_WATCHDOG_EN.
- Defined:
  - A lock-age counter clears on entry to LOCK and on every xfer, and increments on other LOCK cycles.
  - When it reaches WDOG_CYCLES-1 without a transfer, the next edge sets state<=IDLE, ptr<=owner, gnt<=0 and pulses wdog_err for one cycle.
  - credit is unaffected.
- Undefined: no counter is built, a lock persists indefinitely, and wdog_err is tied 0.

Test Plan:
- Reset then req=5'b00101, tail=5'b00101, credit 4 -> gnt=00001 at cycle 1 with xfer=1; IDLE at cycle 2; gnt=00100 at cycle 3 with xfer=1; credit ends at 2.
- Inputs 0 and 3 both send continuous 1-flit packets -> grants alternate 0,3,0,3; neither input is granted twice in a row while the other is requesting.
- Input 1 sends a 6-flit packet with DEPTH=4 and no credit_in -> 4 xfers, then credit=0 and xfer=0 with gnt=00010 held; two credit_in pulses -> 2 more xfers; tail releases the lock, credit=0.
- credit_in pulsed on the same cycle as xfer with credit=2 -> credit stays 2; credit_in at credit=4 with no xfer -> credit stays 4.
- rst asserted while locked mid-packet on input 4 -> next cycle gnt=0, credit=4; with req=11111, the first grant after reset goes to input 0.
- SCHED_WATCHDOG_EN defined, WDOG_CYCLES=8, input 2 granted and then req[2] held low -> release and a one-cycle wdog_err pulse after 8 stalled lock cycles; the next grant goes to input 3 if it is requesting.
